multi_cycle_ctrl: RTL and testbench
===================================

MULTI_CYCLE_CTRL -- requirements
Module: multi_cycle_ctrl

Interface
REQ-001 Parameter OP_W, default 6, opcode width.
REQ-002 Parameter MEM_LAT, default 0, extra wait cycles per memory access (IF, MEM); legal range 0..7.
REQ-003 Parameter CNT_W, default 32, retired-instruction counter width.
REQ-004 CLK  input  1  sole clock; all state changes on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 run  input  1  allow fetch of a new instruction.
REQ-007 opCode  input  OP_W  opcode of the latched instruction.
REQ-008 zero, bne  input  1 each  ALU zero flag, branch-on-not-equal select.
REQ-009 stage  output  3  current state encoding.
REQ-010 pcWrite, irWrite, regWrite, memWrite  output  1 each  single-cycle write strobes.
REQ-011 retired  output  CNT_W  count of completed instructions.

Function
REQ-012 States and encodings: IF=0, ID=1, EXE=2, MEM=3, WB=4, HALT=5.
REQ-013 IF holds while run=0; with run=1, IF lasts MEM_LAT+1 cycles, then goes to ID.
REQ-014 irWrite and pcWrite (PC+4) pulse high only in the last IF cycle.
REQ-015 ID lasts 1 cycle; next state by opcode: 0x00/0x23/0x2B/0x04/0x05 to EXE; 0x03 (jal) to WB; 0x02 (j) and unknown opcodes to IF.
REQ-016 For j and jal, pcWrite pulses in ID.
REQ-017 EXE lasts 1 cycle; next state: R-type (0x00) to WB, lw/sw to MEM, beq/bne to IF.
REQ-018 Branch in EXE: pcWrite = zero XOR bne.
REQ-019 MEM lasts MEM_LAT+1 cycles; next state: lw to WB, sw to IF.
REQ-020 For sw, memWrite pulses in the last MEM cycle only.
REQ-021 WB lasts 1 cycle; regWrite pulses; next state is IF.
REQ-022 retired increments by 1 on every transition into IF from any state except reset.
REQ-023 retired wraps from all-ones to 0.
REQ-024 At most one of the strobes pcWrite/irWrite pulses per cycle, except the IF final cycle (pcWrite+irWrite) and WB of jal (regWrite only; PC already written in ID).
REQ-025 The latency counter reloads on every state entry, so back-to-back memory accesses each get the full MEM_LAT+1 cycles.
REQ-026 The latency counter holds while run=0 in IF.

Reset
REQ-027 reset=1 forces state=IF, latency counter=0, retired=0, and all strobes=0 immediately, independent of CLK.
REQ-028 Reset asserted mid-instruction abandons it with no strobe issued and no retire count.
REQ-029 The first fetch begins on the first rising edge after reset deasserts with run=1.

Configuration
REQ-030 Macro MULTI_CYCLE_CTRL_HALT_EN, when defined: opcode 0x3F in ID goes to HALT.
REQ-031 HALT drives all strobes 0, holds until reset, and increments retired once on entry.
REQ-032 Without MULTI_CYCLE_CTRL_HALT_EN, 0x3F is an unknown opcode (ID to IF) and the HALT encoding is unreachable.

Structure
REQ-033 A shared package holds the state encodings and the opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_JAL, OP_HALT).
REQ-034 One sub-module, mc_wait_counter, holds the loadable MEM_LAT down-counter with a done flag.
REQ-035 The FSM and strobe decode live in multi_cycle_ctrl.

Verification
REQ-036 MEM_LAT=0, run=1, opcode 0x00: stages 0,1,2,4,0; regWrite pulses in cycle 4; retired 0->1.
REQ-037 MEM_LAT=2, lw (0x23): IF takes 3 cycles, MEM takes 3 cycles; 9 cycles total; one regWrite pulse; zero memWrite pulses.
REQ-038 beq with zero=1, bne=0: pcWrite pulses in EXE. bne=1 with zero=1: no pcWrite pulse in EXE; next state IF.
REQ-039 sw, then reset asserted mid-MEM: state=0, strobes=0, and retired unchanged, all asynchronously. After reset release with run=0: state stays IF.
REQ-040 HALT_EN defined, opcode 0x3F: stage=5 and retired+1. Opcode 0x3F without the macro: IF follows ID.
REQ-041 CNT_W=4, 16 j instructions: retired wraps from 15 to 0.

Source files
------------

// File: rtl/multi_cycle_ctrl_pkg.sv
// rtl/multi_cycle_ctrl_pkg.sv - state encodings and opcode constants for multi_cycle_ctrl
package multi_cycle_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IF   = 3'd0,
        ST_ID   = 3'd1,
        ST_EXE  = 3'd2,
        ST_MEM  = 3'd3,
        ST_WB   = 3'd4,
        ST_HALT = 3'd5
    } state_e;

    localparam int unsigned OP_RTYPE = 'h00;
    localparam int unsigned OP_LW    = 'h23;
    localparam int unsigned OP_SW    = 'h2B;
    localparam int unsigned OP_BEQ   = 'h04;
    localparam int unsigned OP_BNE   = 'h05;
    localparam int unsigned OP_J     = 'h02;
    localparam int unsigned OP_JAL   = 'h03;
    localparam int unsigned OP_HALT  = 'h3F;

    // Wide enough for the largest legal MEM_LAT (7).
    localparam int unsigned LAT_W = 3;

endpackage

// File: rtl/mc_wait_counter.sv
// rtl/mc_wait_counter.sv - per-state wait counter; done once MEM_LAT extra cycles have elapsed
module mc_wait_counter
    import multi_cycle_ctrl_pkg::*;
#(
    parameter int unsigned MEM_LAT = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  logic en_i,
    output logic done_o
);

    logic [LAT_W-1:0] cnt_q;
    logic [LAT_W-1:0] cnt_d;

    // Counts elapsed cycles from zero so the reset value already gives a full-length first fetch.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = '0;
        end else if (en_i && !done_o) begin
            cnt_d = cnt_q + LAT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == LAT_W'(MEM_LAT));

endmodule

// File: rtl/multi_cycle_ctrl.sv
// rtl/multi_cycle_ctrl.sv - multi-cycle CPU control FSM; MULTI_CYCLE_CTRL_HALT_EN enables the HALT opcode
module multi_cycle_ctrl
    import multi_cycle_ctrl_pkg::*;
#(
    parameter int unsigned OP_W    = 6,
    parameter int unsigned MEM_LAT = 0,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             run,
    input  logic [OP_W-1:0]  opCode,
    input  logic             zero,
    input  logic             bne,
    output logic [2:0]       stage,
    output logic             pcWrite,
    output logic             irWrite,
    output logic             regWrite,
    output logic             memWrite,
    output logic [CNT_W-1:0] retired
);

    state_e           state_q;
    state_e           state_d;
    logic [CNT_W-1:0] retired_q;
    logic             lat_done;
    logic             lat_load;
    logic             lat_en;
    logic             retire;
    logic             pc_w;
    logic             ir_w;
    logic             reg_w;
    logic             mem_w;

    logic op_rtype;
    logic op_lw;
    logic op_sw;
    logic op_beq;
    logic op_bne;
    logic op_j;
    logic op_jal;
    logic op_exe;

    assign op_rtype = (opCode == OP_W'(OP_RTYPE));
    assign op_lw    = (opCode == OP_W'(OP_LW));
    assign op_sw    = (opCode == OP_W'(OP_SW));
    assign op_beq   = (opCode == OP_W'(OP_BEQ));
    assign op_bne   = (opCode == OP_W'(OP_BNE));
    assign op_j     = (opCode == OP_W'(OP_J));
    assign op_jal   = (opCode == OP_W'(OP_JAL));
    assign op_exe   = op_rtype | op_lw | op_sw | op_beq | op_bne;

`ifdef MULTI_CYCLE_CTRL_HALT_EN
    logic op_halt;
    assign op_halt = (opCode == OP_W'(OP_HALT));
`endif

    always_comb begin
        state_d = state_q;
        pc_w    = 1'b0;
        ir_w    = 1'b0;
        reg_w   = 1'b0;
        mem_w   = 1'b0;
        case (state_q)
            ST_IF: begin
                if (run && lat_done) begin
                    state_d = ST_ID;
                    pc_w    = 1'b1;
                    ir_w    = 1'b1;
                end
            end
            ST_ID: begin
                if (op_exe) begin
                    state_d = ST_EXE;
                end else if (op_jal) begin
                    state_d = ST_WB;
                    pc_w    = 1'b1;
                end else if (op_j) begin
                    state_d = ST_IF;
                    pc_w    = 1'b1;
`ifdef MULTI_CYCLE_CTRL_HALT_EN
                end else if (op_halt) begin
                    state_d = ST_HALT;
`endif
                end else begin
                    state_d = ST_IF;
                end
            end
            ST_EXE: begin
                if (op_rtype) begin
                    state_d = ST_WB;
                end else if (op_lw || op_sw) begin
                    state_d = ST_MEM;
                end else begin
                    state_d = ST_IF;
                    pc_w    = (op_beq || op_bne) && (zero ^ bne);
                end
            end
            ST_MEM: begin
                if (lat_done) begin
                    state_d = op_lw ? ST_WB : ST_IF;
                    mem_w   = op_sw;
                end
            end
            ST_WB: begin
                state_d = ST_IF;
                reg_w   = 1'b1;
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_IF;
            end
        endcase
    end

    // Every state change is an entry, so the wait counter restarts for back-to-back accesses.
    assign lat_load = (state_d != state_q);
    assign lat_en   = !((state_q == ST_IF) && !run);
    assign retire   = (state_d != state_q) && ((state_d == ST_IF) || (state_d == ST_HALT));

    mc_wait_counter #(
        .MEM_LAT (MEM_LAT)
    ) u_wait (
        .clk    (CLK),
        .rst    (reset),
        .load_i (lat_load),
        .en_i   (lat_en),
        .done_o (lat_done)
    );

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IF;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            if (retire) begin
                retired_q <= retired_q + CNT_W'(1);
            end
        end
    end

    // Strobes are masked by reset so an abandoned instruction never writes anything.
    assign pcWrite  = pc_w  & ~reset;
    assign irWrite  = ir_w  & ~reset;
    assign regWrite = reg_w & ~reset;
    assign memWrite = mem_w & ~reset;
    assign stage    = state_q;
    assign retired  = retired_q;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// tb/tb_multi_cycle_ctrl.sv - table-driven scoreboard bench for multi_cycle_ctrl
module tb_multi_cycle_ctrl;

    typedef struct {
        logic        rst;
        logic        run;
        logic [5:0]  op;
        logic        zero;
        logic        bne;
        logic        dsel;
        logic [2:0]  stage;
        logic [3:0]  strb;
        logic [31:0] ret;
    } vec_t;

    logic        CLK = 1'b0;
    logic        reset = 1'b0;
    logic        run = 1'b0;
    logic [5:0]  opCode = 6'h00;
    logic        zero = 1'b0;
    logic        bne = 1'b0;

    logic [2:0]  stage0, stage2;
    logic        pc0, ir0, rg0, mw0, pc2, ir2, rg2, mw2;
    logic [3:0]  ret0;
    logic [31:0] ret2;

    int pass_cnt = 0;
    int total_cnt = 0;
    vec_t vecs[$];
    vec_t exp_q[$];

    always #5 CLK = ~CLK;

    multi_cycle_ctrl #(.OP_W(6), .MEM_LAT(0), .CNT_W(4)) u_dut0 (
        .CLK(CLK), .reset(reset), .run(run), .opCode(opCode), .zero(zero), .bne(bne),
        .stage(stage0), .pcWrite(pc0), .irWrite(ir0), .regWrite(rg0), .memWrite(mw0),
        .retired(ret0)
    );

    multi_cycle_ctrl #(.OP_W(6), .MEM_LAT(2), .CNT_W(32)) u_dut2 (
        .CLK(CLK), .reset(reset), .run(run), .opCode(opCode), .zero(zero), .bne(bne),
        .stage(stage2), .pcWrite(pc2), .irWrite(ir2), .regWrite(rg2), .memWrite(mw2),
        .retired(ret2)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic add(input logic rst_v, input logic run_v, input logic [5:0] op_v,
                       input logic z_v, input logic b_v, input logic d_v,
                       input logic [2:0] st_v, input logic [3:0] sb_v, input int r_v);
        vec_t v;
        v.rst = rst_v; v.run = run_v; v.op = op_v; v.zero = z_v; v.bne = b_v;
        v.dsel = d_v; v.stage = st_v; v.strb = sb_v; v.ret = 32'(r_v);
        vecs.push_back(v);
    endtask

    task automatic check_dut(input string tag, input logic d, input logic [2:0] st,
                             input logic [3:0] sb, input logic [31:0] r);
        if (d == 1'b0) begin
            chk({tag, " stage"}, {29'd0, stage0}, {29'd0, st});
            chk({tag, " strobes"}, {28'd0, pc0, ir0, rg0, mw0}, {28'd0, sb});
            chk({tag, " retired"}, {28'd0, ret0}, r);
        end else begin
            chk({tag, " stage"}, {29'd0, stage2}, {29'd0, st});
            chk({tag, " strobes"}, {28'd0, pc2, ir2, rg2, mw2}, {28'd0, sb});
            chk({tag, " retired"}, ret2, r);
        end
    endtask

    initial begin
        vec_t e;
        // strobes column is {pcWrite, irWrite, regWrite, memWrite}
        // dut0, MEM_LAT=0: R-type, beq taken, bne not taken, run hold, jal, j, sw, lw, 0x3F
        add(1,1,6'h00,0,0,0,3'd0,4'b0000,0);
        add(0,1,6'h00,0,0,0,3'd0,4'b1100,0);
        add(0,1,6'h00,0,0,0,3'd1,4'b0000,0);
        add(0,1,6'h00,0,0,0,3'd2,4'b0000,0);
        add(0,1,6'h00,0,0,0,3'd4,4'b0010,0);
        add(0,1,6'h04,1,0,0,3'd0,4'b1100,1);
        add(0,1,6'h04,1,0,0,3'd1,4'b0000,1);
        add(0,1,6'h04,1,0,0,3'd2,4'b1000,1);
        add(0,1,6'h05,1,1,0,3'd0,4'b1100,2);
        add(0,1,6'h05,1,1,0,3'd1,4'b0000,2);
        add(0,1,6'h05,1,1,0,3'd2,4'b0000,2);
        add(0,0,6'h03,0,0,0,3'd0,4'b0000,3);
        add(0,0,6'h03,0,0,0,3'd0,4'b0000,3);
        add(0,1,6'h03,0,0,0,3'd0,4'b1100,3);
        add(0,1,6'h03,0,0,0,3'd1,4'b1000,3);
        add(0,1,6'h03,0,0,0,3'd4,4'b0010,3);
        add(0,1,6'h02,0,0,0,3'd0,4'b1100,4);
        add(0,1,6'h02,0,0,0,3'd1,4'b1000,4);
        add(0,1,6'h2B,0,0,0,3'd0,4'b1100,5);
        add(0,1,6'h2B,0,0,0,3'd1,4'b0000,5);
        add(0,1,6'h2B,0,0,0,3'd2,4'b0000,5);
        add(0,1,6'h2B,0,0,0,3'd3,4'b0001,5);
        add(0,1,6'h23,0,0,0,3'd0,4'b1100,6);
        add(0,1,6'h23,0,0,0,3'd1,4'b0000,6);
        add(0,1,6'h23,0,0,0,3'd2,4'b0000,6);
        add(0,1,6'h23,0,0,0,3'd3,4'b0000,6);
        add(0,1,6'h23,0,0,0,3'd4,4'b0010,6);
        add(0,1,6'h3F,0,0,0,3'd0,4'b1100,7);
        add(0,1,6'h3F,0,0,0,3'd1,4'b0000,7);
`ifdef MULTI_CYCLE_CTRL_HALT_EN
        add(0,1,6'h3F,0,0,0,3'd5,4'b0000,8);
        add(0,1,6'h3F,0,0,0,3'd5,4'b0000,8);
`else
        add(0,1,6'h3F,0,0,0,3'd0,4'b1100,8);
        add(0,1,6'h3F,0,0,0,3'd1,4'b0000,8);
`endif
        // dut0, CNT_W=4: sixteen j instructions wrap retired from 15 to 0
        add(1,1,6'h02,0,0,0,3'd0,4'b0000,0);
        for (int k = 0; k < 16; k++) begin
            add(0,1,6'h02,0,0,0,3'd0,4'b1100,k);
            add(0,1,6'h02,0,0,0,3'd1,4'b1000,k);
        end
        add(0,0,6'h02,0,0,0,3'd0,4'b0000,0);
        // dut2, MEM_LAT=2: lw in 9 cycles, then sw with a run=0 pause mid-fetch
        add(1,1,6'h23,0,0,1,3'd0,4'b0000,0);
        add(0,1,6'h23,0,0,1,3'd0,4'b0000,0);
        add(0,1,6'h23,0,0,1,3'd0,4'b0000,0);
        add(0,1,6'h23,0,0,1,3'd0,4'b1100,0);
        add(0,1,6'h23,0,0,1,3'd1,4'b0000,0);
        add(0,1,6'h23,0,0,1,3'd2,4'b0000,0);
        add(0,1,6'h23,0,0,1,3'd3,4'b0000,0);
        add(0,1,6'h23,0,0,1,3'd3,4'b0000,0);
        add(0,1,6'h23,0,0,1,3'd3,4'b0000,0);
        add(0,1,6'h23,0,0,1,3'd4,4'b0010,0);
        add(0,1,6'h2B,0,0,1,3'd0,4'b0000,1);
        add(0,0,6'h2B,0,0,1,3'd0,4'b0000,1);
        add(0,0,6'h2B,0,0,1,3'd0,4'b0000,1);
        add(0,1,6'h2B,0,0,1,3'd0,4'b0000,1);
        add(0,1,6'h2B,0,0,1,3'd0,4'b1100,1);
        add(0,1,6'h2B,0,0,1,3'd1,4'b0000,1);
        add(0,1,6'h2B,0,0,1,3'd2,4'b0000,1);
        add(0,1,6'h2B,0,0,1,3'd3,4'b0000,1);
        add(0,1,6'h2B,0,0,1,3'd3,4'b0000,1);
        add(0,1,6'h2B,0,0,1,3'd3,4'b0001,1);
        add(0,0,6'h2B,0,0,1,3'd0,4'b0000,2);

        // Asynchronous reset before any clock edge.
        run = 1'b1;
        #1 reset = 1'b1;
        #2;
        check_dut("async_reset0", 1'b0, 3'd0, 4'b0000, 32'd0);
        check_dut("async_reset2", 1'b1, 3'd0, 4'b0000, 32'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge CLK);
            reset = vecs[i].rst; run = vecs[i].run; opCode = vecs[i].op;
            zero = vecs[i].zero; bne = vecs[i].bne;
            exp_q.push_back(vecs[i]);
            #2;
            e = exp_q.pop_front();
            check_dut($sformatf("vec%0d", i), e.dsel, e.stage, e.strb, e.ret);
        end

        // sw on dut2 abandoned by reset in the final MEM cycle.
        @(negedge CLK);
        reset = 1'b1; run = 1'b1; opCode = 6'h2B; zero = 1'b0; bne = 1'b0;
        @(negedge CLK);
        reset = 1'b0;
        repeat (7) @(negedge CLK);
        #2;
        check_dut("sw_last_mem", 1'b1, 3'd3, 4'b0001, 32'd0);
        #1 reset = 1'b1;
        #1;
        check_dut("mid_mem_reset", 1'b1, 3'd0, 4'b0000, 32'd0);
        @(negedge CLK);
        reset = 1'b0; run = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge CLK);
            #2;
            check_dut($sformatf("idle_after_reset%0d", c), 1'b1, 3'd0, 4'b0000, 32'd0);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
